golay24_dec_cand_sched: RTL and testbench

Candidate scheduler for the Golay(24,12) soft decoder. It accepts channel words (hard decision, metric, tag) over a valid/ready handshake and buffers them in a 2-entry FIFO. For each word it emits one framed burst of pCAND_NUM candidate slots (sop/val/eop plus candidate index) that sequences the candidate generator and the ML decision unit. It sits between the channel front end and the candidate ROM/decision pipeline, and keeps that pipeline busy back-to-back whenever words are queued.

---
 rtl/golay24_dec_cand_sched.sv | 97 +++++++++
 tb/tb_golay24_dec_cand_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/golay24_dec_cand_sched.sv
// Candidate scheduler for the Golay(24,12) soft decoder: buffers channel words in a
// 2-entry FIFO and emits one sop/val/eop framed burst of pCAND_NUM candidate slots per word.
module golay24_dec_cand_sched #(
  parameter int pLLR_W    = 4,
  parameter int pTAG_W    = 1,
  parameter int pCAND_NUM = 17,
  localparam int cMETRIC_W = pLLR_W + 5
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 iclkena,
  input  logic                 ival,
  input  logic [pTAG_W-1:0]    itag,
  input  logic [23:0]          ich_hd,
  input  logic [cMETRIC_W-1:0] ich_metric,
  output logic                 ordy,
  output logic                 osop,
  output logic                 oval,
  output logic                 oeop,
  output logic [4:0]           ocand_idx,
  output logic [pTAG_W-1:0]    otag,
  output logic [23:0]          och_hd,
  output logic [cMETRIC_W-1:0] och_metric,
  output logic                 obusy
);

  localparam logic [0:0] cST_IDLE  = 1'b0;
  localparam logic [0:0] cST_BURST = 1'b1;
  localparam int         cWORD_W   = pTAG_W + 24 + cMETRIC_W;
  localparam logic [4:0] cLAST     = 5'(pCAND_NUM - 1);

  logic [cWORD_W-1:0] mem [2];
  logic               wptr;
  logic               rptr;
  logic [1:0]         count;
  logic [0:0]         state;
  logic               wr;
  logic               pop;
  logic               last;

  assign ordy  = (count != 2'd2);
  assign wr    = iclkena & ival & ordy;
  assign last  = (ocand_idx == cLAST);
  // A word leaves the FIFO exactly when its burst starts: from idle, or right after eop.
  assign pop   = iclkena & (count != 2'd0) & ((state == cST_IDLE) | last);
  assign obusy = (state == cST_BURST) | (count != 2'd0);

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (wr)  wptr <= ~wptr;
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, wr} - {1'b0, pop};
    end
  end

  always_ff @(posedge iclk) begin
    if (wr) mem[wptr] <= {itag, ich_hd, ich_metric};
  end

  always_ff @(posedge iclk) begin
    if (pop) {otag, och_hd, och_metric} <= mem[rptr];
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state     <= cST_IDLE;
      ocand_idx <= 5'd0;
      osop      <= 1'b0;
      oval      <= 1'b0;
      oeop      <= 1'b0;
    end else if (iclkena) begin
      if (pop) begin
        state     <= cST_BURST;
        ocand_idx <= 5'd0;
        osop      <= 1'b1;
        oval      <= 1'b1;
        oeop      <= 1'b0;
      end else if (state == cST_BURST) begin
        if (last) begin
          state <= cST_IDLE;
          osop  <= 1'b0;
          oval  <= 1'b0;
          oeop  <= 1'b0;
        end else begin
          ocand_idx <= ocand_idx + 5'd1;
          osop      <= 1'b0;
          oeop      <= ((ocand_idx + 5'd1) == cLAST);
        end
      end
    end
  end

endmodule

// File: tb/tb_golay24_dec_cand_sched.sv
// Self-checking bench: two schedulers (17 and 2 candidates) driven by the same stimulus,
// each compared every cycle against a queue-based transaction model of the scheduler.
module tb_golay24_dec_cand_sched;

  localparam int cTAG_W = 1;
  localparam int cMW    = 9;

  typedef struct packed {
    logic [cTAG_W-1:0] tag;
    logic [23:0]       hd;
    logic [cMW-1:0]    metric;
  } word_t;

  logic              iclk = 1'b0;
  logic              ireset = 1'b1;
  logic              iclkena = 1'b1;
  logic              ival = 1'b0;
  logic [cTAG_W-1:0] itag = '0;
  logic [23:0]       ich_hd = '0;
  logic [cMW-1:0]    ich_metric = '0;

  logic [1:0]        ordy_w, osop_w, oval_w, oeop_w, obusy_w;
  logic [4:0]        idx_w [2];
  logic [cTAG_W-1:0] tag_w [2];
  logic [23:0]       hd_w [2];
  logic [cMW-1:0]    met_w [2];

  int checks = 0;
  int failures = 0;

  word_t q [2][$];
  bit    act [2];
  bit    have [2];
  bit    acc [2];
  int    slot [2];
  word_t cur [2];
  int    ncand [2] = '{17, 2};

  always #5 iclk = ~iclk;

  golay24_dec_cand_sched #(.pLLR_W(4), .pTAG_W(cTAG_W), .pCAND_NUM(17)) dut0 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .itag(itag),
    .ich_hd(ich_hd), .ich_metric(ich_metric), .ordy(ordy_w[0]), .osop(osop_w[0]),
    .oval(oval_w[0]), .oeop(oeop_w[0]), .ocand_idx(idx_w[0]), .otag(tag_w[0]),
    .och_hd(hd_w[0]), .och_metric(met_w[0]), .obusy(obusy_w[0]));

  golay24_dec_cand_sched #(.pLLR_W(4), .pTAG_W(cTAG_W), .pCAND_NUM(2)) dut1 (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .itag(itag),
    .ich_hd(ich_hd), .ich_metric(ich_metric), .ordy(ordy_w[1]), .osop(osop_w[1]),
    .oval(oval_w[1]), .oeop(oeop_w[1]), .ocand_idx(idx_w[1]), .otag(tag_w[1]),
    .och_hd(hd_w[1]), .och_metric(met_w[1]), .obusy(obusy_w[1]));

  task automatic checkVal(input string tag, input int d, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      act[d]  = 1'b0;
      acc[d]  = 1'b0;
      slot[d] = 0;
    end
  endtask

  // One enabled clock edge: the word in service advances a slot, or a new one is taken
  // from the queue once the current burst has delivered its last slot.
  task automatic modelEdge();
    for (int d = 0; d < 2; d++) begin
      acc[d] = 1'b0;
      if (ireset) begin
        q[d].delete();
        act[d]  = 1'b0;
        slot[d] = 0;
      end else if (iclkena) begin
        acc[d] = ival && (q[d].size() < 2);
        if (!act[d] || slot[d] == ncand[d] - 1) begin
          if (q[d].size() > 0) begin
            cur[d]  = q[d].pop_front();
            slot[d] = 0;
            act[d]  = 1'b1;
            have[d] = 1'b1;
          end else begin
            act[d] = 1'b0;
          end
        end else begin
          slot[d]++;
        end
        if (acc[d]) q[d].push_back(word_t'{itag, ich_hd, ich_metric});
      end
    end
  endtask

  task automatic checkOutput();
    for (int d = 0; d < 2; d++) begin
      checkVal("oval", d, oval_w[d], act[d]);
      checkVal("osop", d, osop_w[d], act[d] && slot[d] == 0);
      checkVal("oeop", d, oeop_w[d], act[d] && slot[d] == ncand[d] - 1);
      checkVal("ocand_idx", d, idx_w[d], slot[d]);
      checkVal("ordy", d, ordy_w[d], q[d].size() < 2);
      checkVal("obusy", d, obusy_w[d], act[d] || q[d].size() > 0);
      if (have[d]) begin
        checkVal("och_hd", d, hd_w[d], cur[d].hd);
        checkVal("otag", d, tag_w[d], cur[d].tag);
        checkVal("och_metric", d, met_w[d], cur[d].metric);
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge iclk);
    modelEdge();
    @(negedge iclk);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic v, input logic [cTAG_W-1:0] t,
                               input logic [23:0] hd, input logic [cMW-1:0] m);
    ival       = v;
    itag       = t;
    ich_hd     = hd;
    ich_metric = m;
  endtask

  task automatic sendWords(input int n, input bit fixed_tags);
    int sent = 0;
    applyStimulus(1'b1, fixed_tags ? 1'(0) : 1'($urandom), 24'($urandom), 9'($urandom));
    for (int c = 0; c < 200 && sent < n; c++) begin
      stepCycle();
      if (acc[0]) begin
        sent++;
        applyStimulus(1'b1, fixed_tags ? 1'(sent % 2) : 1'($urandom),
                      24'($urandom), 9'($urandom));
      end
    end
    applyStimulus(1'b0, '0, '0, '0);
    checkVal("words_sent", 0, sent, n);
  endtask

  initial begin
    int sops;
    modelReset();
    have[0] = 1'b0;
    have[1] = 1'b0;

    // Reset state
    stepCycle();
    stepCycle();
    ireset = 1'b0;
    stepCycle();
    checkVal("rst_ordy", 0, ordy_w[0], 1);
    checkVal("rst_obusy", 0, obusy_w[0], 0);

    // Single word: latency, length, held data
    applyStimulus(1'b1, 1'b1, 24'hABC123, 9'h155);
    stepCycle();
    checkVal("lat_k_oval", 0, oval_w[0], 0);
    applyStimulus(1'b0, '0, '0, '0);
    stepCycle();
    checkVal("lat_k1_osop", 0, osop_w[0], 1);
    checkVal("single_hd", 0, hd_w[0], 24'hABC123);
    for (int i = 0; i < 20; i++) stepCycle();
    checkVal("single_done", 0, oval_w[0], 0);

    // Three words back to back with tags 0,1,0
    sendWords(3, 1'b1);
    for (int i = 0; i < 60; i++) stepCycle();

    // Continuous ival over 20 words, count the bursts delivered
    sops = 0;
    applyStimulus(1'b1, 1'($urandom), 24'($urandom), 9'($urandom));
    begin
      int sent = 0;
      for (int c = 0; c < 1000 && sent < 20; c++) begin
        stepCycle();
        if (osop_w[0]) sops++;
        if (acc[0]) begin
          sent++;
          applyStimulus(1'b1, 1'($urandom), 24'($urandom), 9'($urandom));
        end
      end
      checkVal("cont_sent", 0, sent, 20);
    end
    applyStimulus(1'b0, '0, '0, '0);
    for (int i = 0; i < 60; i++) begin
      stepCycle();
      if (osop_w[0]) sops++;
    end
    checkVal("cont_bursts", 0, sops, 20);

    // Clock enable freeze at idx 5
    sendWords(1, 1'b0);
    for (int i = 0; i < 40 && !(act[0] && slot[0] == 5); i++) stepCycle();
    checkVal("reach_idx5", 0, idx_w[0], 5);
    iclkena = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    checkVal("frozen_idx", 0, idx_w[0], 5);
    iclkena = 1'b1;
    for (int i = 0; i < 30; i++) stepCycle();

    // Asynchronous reset at idx 8 with two words queued
    sendWords(3, 1'b0);
    for (int i = 0; i < 40 && !(act[0] && slot[0] == 8); i++) stepCycle();
    checkVal("reach_idx8", 0, idx_w[0], 8);
    ireset = 1'b1;
    #1;
    modelReset();
    for (int d = 0; d < 2; d++) begin
      checkVal("arst_oval", d, oval_w[d], 0);
      checkVal("arst_ordy", d, ordy_w[d], 1);
      checkVal("arst_obusy", d, obusy_w[d], 0);
    end
    stepCycle();
    stepCycle();
    ireset = 1'b0;
    applyStimulus(1'b1, 1'b0, 24'h5A5A5A, 9'h0F0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, '0);
    stepCycle();
    checkVal("post_rst_idx", 0, idx_w[0], 0);
    checkVal("post_rst_hd", 0, hd_w[0], 24'h5A5A5A);
    for (int i = 0; i < 20; i++) stepCycle();

    // Random traffic with random clock enable
    for (int i = 0; i < 400; i++) begin
      iclkena = ($urandom_range(0, 9) != 0);
      applyStimulus(1'($urandom_range(0, 2) != 0), 1'($urandom), 24'($urandom), 9'($urandom));
      stepCycle();
    end
    iclkena = 1'b1;
    applyStimulus(1'b0, '0, '0, '0);
    for (int i = 0; i < 60; i++) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
